m_virtio_mmio: RTL and testbench
================================

M_VIRTIO_MMIO -- requirements
Module: m_virtio_mmio

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 1, number of virtqueues (1..16).
REQ-002 SHALL have parameter QUEUE_NUM_MAX, default 8, value returned by QueueNumMax.
REQ-003 SHALL have parameter DEVICE_ID, default 2, virtio device ID (2 = block).
REQ-004 SHALL have parameter FEATURES, default 64'h1, 64-bit device feature set.
REQ-005 SHALL have port CLK, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port RST_X, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports w_cpu_we (input, 1), w_cpu_addr (input, 12), w_cpu_wdata (input, 32) and w_cpu_rdata (output, 32), the CPU MMIO port; every cycle is a read.
REQ-008 SHALL have ports w_mc_we (input, 1), w_mc_addr (input, 12), w_mc_wdata (input, 32) and w_mc_rdata (output, 32), the micro-controller queue-state port.
REQ-009 SHALL have ports w_req (output, 1), w_qsel (output, 4) and w_qnum (output, 32): notify pending, head queue index, and that queue's QueueNum.
REQ-010 SHALL have ports w_ack (input, 1), w_used (input, 1) and w_cfg_chg (input, 1): pop head, used-buffer interrupt pulse, config-change pulse.
REQ-011 SHALL have ports w_capacity (input, 64), disk capacity in sectors, and w_irq (output, 1), level interrupt.

Function
REQ-012 SHALL register both read ports: data for the address presented in cycle N appears in cycle N+1; unmapped addresses read 0.
REQ-013 SHALL return constants on CPU reads: 0x00 0x74726976, 0x04 2, 0x08 DEVICE_ID, 0x0c 0xffff.
REQ-014 SHALL return FEATURES[31:0] at 0x10 when DeviceFeaturesSel (0x14) is 0, FEATURES[63:32] when it is 1, and 0 otherwise.
REQ-015 SHALL store writes to 0x20 into DriverFeatures word DriverFeaturesSel (0x24) when that selector is 0 or 1, and ignore them otherwise.
REQ-016 SHALL hold per queue 8 words: Ready, Num, DescLo/Hi, AvailLo/Hi, UsedLo/Hi.
REQ-017 SHALL map those words on the CPU port to 0x44, 0x38, 0x80/0x84, 0x90/0x94 and 0xa0/0xa4, all indexed by QueueSel (0x30).
REQ-018 SHALL, when QueueSel >= NUM_QUEUES, read all per-queue registers and 0x34 as 0 and ignore writes to them; otherwise 0x34 reads QUEUE_NUM_MAX.
REQ-019 SHALL ignore a write to 0x38 whose value exceeds QUEUE_NUM_MAX.
REQ-020 SHALL address the micro-controller port by word index q*8+k, with k = w_mc_addr[4:2] and q = w_mc_addr[8:5]; q >= NUM_QUEUES reads 0 and ignores writes.
REQ-021 SHALL let the CPU write win when the CPU and the micro-controller write the same word in the same cycle.
REQ-022 SHALL handle a write of value v to 0x50 (QueueNotify): if v < NUM_QUEUES and pending[v] is 0, push v into a NUM_QUEUES-deep FIFO and set pending[v]; otherwise drop it (coalescing), so the FIFO never overflows.
REQ-023 SHALL drive w_req high while the FIFO is non-empty, with w_qsel = head and w_qnum = Num[head].
REQ-024 SHALL, on w_ack with w_req high, pop the head and clear pending[head]; w_ack while the FIFO is empty has no effect.
REQ-025 SHALL, when a pop of queue q and a notify of q occur in the same cycle, perform the pop and then the push, leaving q pending and queued once.
REQ-026 SHALL have InterruptStatus (0x60) bit0 set by w_used and bit1 set by w_cfg_chg.
REQ-027 SHALL clear InterruptStatus bits by a write of a mask to 0x64; set wins over clear in the same cycle.
REQ-028 SHALL hold w_irq = |InterruptStatus, updated the cycle after the change.
REQ-029 SHALL increment ConfigGeneration (0xfc) on each w_cfg_chg pulse, wrapping at 2^32.
REQ-030 SHALL read w_capacity[31:0] at 0x100 and w_capacity[63:32] at 0x104.
REQ-031 SHALL store writes to Status (0x70); a write of 0 performs a device reset the next cycle, with the same effect as RST_X except that ConfigGeneration is kept.

Reset
REQ-032 SHALL, on RST_X low, asynchronously clear: all queue words, pending bits, FIFO, InterruptStatus, ConfigGeneration, all selectors, DriverFeatures, both rdata registers and Status.
REQ-033 SHALL hold all outputs at 0 during reset, including w_req and w_irq.

Verification
REQ-034 SHALL cover this scenario: read 0x00 after reset -> 0x74726976 next cycle; write 0x14=1, read 0x10 -> FEATURES[63:32].
REQ-035 SHALL cover this scenario: NUM_QUEUES=2; write 0x50=1 twice, then 0x50=0 -> w_req=1, w_qsel=1; w_ack -> w_qsel=0; w_ack -> w_req=0 (duplicate coalesced).
REQ-036 SHALL cover this scenario: QueueSel=0, write 0x38=9 with QUEUE_NUM_MAX=8 -> 0x38 stays 0; write 8 -> w_qnum=8 when queue 0 is at the head.
REQ-037 SHALL cover this scenario: w_used and a write of 0x64=1 in the same cycle -> 0x60 reads 1 and w_irq=1; a later write of 0x64=1 -> w_irq=0.
REQ-038 SHALL cover this scenario: CPU write of 0x80=0x1000 and MC write of word 2=0x2000 in the same cycle -> both ports read 0x1000.
REQ-039 SHALL cover this scenario: pending notify plus w_cfg_chg, then a write of 0x70=0 -> w_req=0, w_irq=0, 0xfc reads 1.

Source files
------------

// File: rtl/m_virtio_mmio.sv
// m_virtio_mmio: virtio-mmio register block with per-queue state, notify FIFO and interrupt status.
module m_virtio_mmio #(
  parameter int          NUM_QUEUES    = 1,
  parameter int          QUEUE_NUM_MAX = 8,
  parameter int          DEVICE_ID     = 2,
  parameter logic [63:0] FEATURES      = 64'h1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        w_cpu_we,
  input  logic [11:0] w_cpu_addr,
  input  logic [31:0] w_cpu_wdata,
  output logic [31:0] w_cpu_rdata,
  input  logic        w_mc_we,
  input  logic [11:0] w_mc_addr,
  input  logic [31:0] w_mc_wdata,
  output logic [31:0] w_mc_rdata,
  output logic        w_req,
  output logic [3:0]  w_qsel,
  output logic [31:0] w_qnum,
  input  logic        w_ack,
  input  logic        w_used,
  input  logic        w_cfg_chg,
  input  logic [63:0] w_capacity,
  output logic        w_irq
);
  localparam int NW = NUM_QUEUES * 8;
  logic [31:0] q_mem [NW];
  logic [31:0] drv_feat [2];
  logic [31:0] dev_feat_sel, drv_feat_sel, queue_sel, status, config_gen;
  logic [15:0] pending, pend_eff;
  logic [3:0]  fifo [16];
  logic [3:0]  head, tail, head_q, nq;
  logic [4:0]  count;
  logic [1:0]  int_status, int_clr;
  logic [2:0]  cpu_k;
  logic        cpu_qhit, q_ok, mc_ok, cpu_qw, mc_qw, srst, pop, push, unused_bits;
  logic [6:0]  cpu_widx, mc_widx, head_widx;
  logic [31:0] cpu_word, mc_word, head_num, cpu_rd, feat_rd, drv_rd;
  function automatic logic [3:0] nxt(input logic [3:0] p);
    nxt = (p == 4'(NUM_QUEUES - 1)) ? 4'd0 : p + 4'd1;
  endfunction
  assign q_ok      = queue_sel < 32'(NUM_QUEUES);
  assign mc_ok     = {1'b0, w_mc_addr[8:5]} < 5'(NUM_QUEUES);
  assign cpu_widx  = {queue_sel[3:0], cpu_k};
  assign mc_widx   = w_mc_addr[8:2];
  assign head_q    = fifo[head];
  assign head_widx = {head_q, 3'd1};
  assign cpu_qw    = w_cpu_we && cpu_qhit && q_ok && !(cpu_k == 3'd1 && w_cpu_wdata > 32'(QUEUE_NUM_MAX));
  assign mc_qw     = w_mc_we && mc_ok;
  assign srst      = w_cpu_we && w_cpu_addr == 12'h070 && w_cpu_wdata == 32'd0;
  assign pop       = w_ack && count != 5'd0;
  assign nq        = w_cpu_wdata[3:0];
  // a same-cycle pop frees the head's pending bit before the notify is judged
  assign pend_eff  = pending & ~(pop ? 16'd1 << head_q : 16'd0);
  assign push      = w_cpu_we && w_cpu_addr == 12'h050 && w_cpu_wdata < 32'(NUM_QUEUES) && !pend_eff[nq];
  assign int_clr   = (w_cpu_we && w_cpu_addr == 12'h064) ? w_cpu_wdata[1:0] : 2'b00;
  assign w_req     = count != 5'd0;
  assign w_qsel    = w_req ? head_q : 4'd0;
  assign w_qnum    = w_req ? head_num : 32'd0;
  assign w_irq     = |int_status;
  assign feat_rd   = dev_feat_sel == 32'd0 ? FEATURES[31:0] : dev_feat_sel == 32'd1 ? FEATURES[63:32] : 32'd0;
  assign drv_rd    = drv_feat_sel == 32'd0 ? drv_feat[0] : drv_feat_sel == 32'd1 ? drv_feat[1] : 32'd0;
  assign unused_bits = &{1'b0, w_mc_addr[11:9], w_mc_addr[1:0]};
  always_comb begin
    cpu_k = 3'd0;
    cpu_qhit = 1'b1;
    case (w_cpu_addr)
      12'h044: cpu_k = 3'd0;
      12'h038: cpu_k = 3'd1;
      12'h080: cpu_k = 3'd2;
      12'h084: cpu_k = 3'd3;
      12'h090: cpu_k = 3'd4;
      12'h094: cpu_k = 3'd5;
      12'h0a0: cpu_k = 3'd6;
      12'h0a4: cpu_k = 3'd7;
      default: cpu_qhit = 1'b0;
    endcase
  end
  always_comb begin
    cpu_word = 32'd0;
    mc_word = 32'd0;
    head_num = 32'd0;
    for (int i = 0; i < NW; i++) begin
      if (cpu_widx == 7'(i)) cpu_word = q_mem[i];
      if (mc_widx == 7'(i)) mc_word = q_mem[i];
      if (head_widx == 7'(i)) head_num = q_mem[i];
    end
  end
  always_comb begin
    case (w_cpu_addr)
      12'h000: cpu_rd = 32'h7472_6976;
      12'h004: cpu_rd = 32'd2;
      12'h008: cpu_rd = 32'(DEVICE_ID);
      12'h00c: cpu_rd = 32'h0000_ffff;
      12'h010: cpu_rd = feat_rd;
      12'h014: cpu_rd = dev_feat_sel;
      12'h020: cpu_rd = drv_rd;
      12'h024: cpu_rd = drv_feat_sel;
      12'h030: cpu_rd = queue_sel;
      12'h034: cpu_rd = q_ok ? 32'(QUEUE_NUM_MAX) : 32'd0;
      12'h060: cpu_rd = {30'd0, int_status};
      12'h070: cpu_rd = status;
      12'h0fc: cpu_rd = config_gen;
      12'h100: cpu_rd = w_capacity[31:0];
      12'h104: cpu_rd = w_capacity[63:32];
      default: cpu_rd = (cpu_qhit && q_ok) ? cpu_word : 32'd0;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) begin
      config_gen <= '0;
      w_cpu_rdata <= '0;
      w_mc_rdata <= '0;
      dev_feat_sel <= '0;
      drv_feat_sel <= '0;
      queue_sel <= '0;
      status <= '0;
      drv_feat[0] <= '0;
      drv_feat[1] <= '0;
      pending <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      int_status <= '0;
      for (int i = 0; i < NW; i++) q_mem[i] <= '0;
      for (int i = 0; i < 16; i++) fifo[i] <= '0;
    end else begin
      config_gen <= config_gen + {31'd0, w_cfg_chg};
      if (srst) begin
        w_cpu_rdata <= '0;
        w_mc_rdata <= '0;
        dev_feat_sel <= '0;
        drv_feat_sel <= '0;
        queue_sel <= '0;
        status <= '0;
        drv_feat[0] <= '0;
        drv_feat[1] <= '0;
        pending <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
        int_status <= '0;
        for (int i = 0; i < NW; i++) q_mem[i] <= '0;
        for (int i = 0; i < 16; i++) fifo[i] <= '0;
      end else begin
        w_cpu_rdata <= cpu_rd;
        w_mc_rdata <= mc_ok ? mc_word : 32'd0;
        if (w_cpu_we && w_cpu_addr == 12'h014) dev_feat_sel <= w_cpu_wdata;
        if (w_cpu_we && w_cpu_addr == 12'h024) drv_feat_sel <= w_cpu_wdata;
        if (w_cpu_we && w_cpu_addr == 12'h030) queue_sel <= w_cpu_wdata;
        if (w_cpu_we && w_cpu_addr == 12'h070) status <= w_cpu_wdata;
        if (w_cpu_we && w_cpu_addr == 12'h020 && drv_feat_sel < 32'd2) drv_feat[drv_feat_sel[0]] <= w_cpu_wdata;
        for (int i = 0; i < NW; i++)
          if (cpu_qw && cpu_widx == 7'(i)) q_mem[i] <= w_cpu_wdata;
          else if (mc_qw && mc_widx == 7'(i)) q_mem[i] <= w_mc_wdata;
        pending <= pend_eff | (push ? 16'd1 << nq : 16'd0);
        if (push) fifo[tail] <= nq;
        if (push) tail <= nxt(tail);
        if (pop) head <= nxt(head);
        count <= count + 5'(push) - 5'(pop);
        int_status <= (int_status & ~int_clr) | {w_cfg_chg, w_used};
      end
    end
endmodule

// File: tb/tb_m_virtio_mmio.sv
// tb_m_virtio_mmio: directed scenarios for the virtio-mmio register block.
module tb_m_virtio_mmio;
  localparam logic [63:0] FEAT = 64'h1234_5678_0000_0001;
  logic        CLK = 0, RST_X = 0;
  logic        w_cpu_we = 0, w_mc_we = 0, w_ack = 0, w_used = 0, w_cfg_chg = 0;
  logic [11:0] w_cpu_addr = 0, w_mc_addr = 0;
  logic [31:0] w_cpu_wdata = 0, w_mc_wdata = 0;
  logic [31:0] w_cpu_rdata, w_mc_rdata, w_qnum;
  logic        w_req, w_irq;
  logic [3:0]  w_qsel;
  logic [63:0] w_capacity = 64'h0000_00ab_1234_5678;
  int checks = 0, errors = 0;
  m_virtio_mmio #(.NUM_QUEUES(2), .QUEUE_NUM_MAX(8), .DEVICE_ID(2), .FEATURES(FEAT)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_cpu_we(w_cpu_we), .w_cpu_addr(w_cpu_addr), .w_cpu_wdata(w_cpu_wdata), .w_cpu_rdata(w_cpu_rdata),
    .w_mc_we(w_mc_we), .w_mc_addr(w_mc_addr), .w_mc_wdata(w_mc_wdata), .w_mc_rdata(w_mc_rdata),
    .w_req(w_req), .w_qsel(w_qsel), .w_qnum(w_qnum),
    .w_ack(w_ack), .w_used(w_used), .w_cfg_chg(w_cfg_chg),
    .w_capacity(w_capacity), .w_irq(w_irq)
  );
  always #5 CLK = ~CLK;
  task automatic cpu_wr(input logic [11:0] a, input logic [31:0] d);
    w_cpu_we = 1; w_cpu_addr = a; w_cpu_wdata = d;
    @(posedge CLK); #1;
    w_cpu_we = 0;
  endtask
  task automatic cpu_rd(input logic [11:0] a, output logic [31:0] d);
    w_cpu_addr = a;
    @(posedge CLK); #1;
    d = w_cpu_rdata;
  endtask
  task automatic mc_rd(input logic [11:0] a, output logic [31:0] d);
    w_mc_addr = a;
    @(posedge CLK); #1;
    d = w_mc_rdata;
  endtask
  task automatic ack;
    w_ack = 1;
    @(posedge CLK); #1;
    w_ack = 0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    w_used = 1; w_cfg_chg = 1;
    #2;
    checks++; if ({w_req, w_irq, w_qsel} !== 6'd0) begin errors++; $display("FAIL reset_flags got %b exp 0", {w_req, w_irq, w_qsel}); end
    @(posedge CLK); @(posedge CLK); #1;
    checks++; if (w_irq !== 1'b0) begin errors++; $display("FAIL reset_irq_held got %b exp 0", w_irq); end
    checks++; if ({w_cpu_rdata, w_mc_rdata, w_qnum} !== 96'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {w_cpu_rdata, w_mc_rdata, w_qnum}); end
    w_used = 0; w_cfg_chg = 0;
    #5 RST_X = 1;
    @(posedge CLK); #1;
    cpu_rd(12'h0fc, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_cfggen got %h exp 0", d); end
    cpu_rd(12'h070, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
  endtask
  task automatic test_ids;
    logic [31:0] d;
    cpu_rd(12'h000, d);
    checks++; if (d !== 32'h7472_6976) begin errors++; $display("FAIL magic got %h exp %h", d, 32'h7472_6976); end
    cpu_rd(12'h004, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL version got %h exp 2", d); end
    cpu_rd(12'h008, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL devid got %h exp 2", d); end
    cpu_rd(12'h00c, d);
    checks++; if (d !== 32'h0000_ffff) begin errors++; $display("FAIL vendor got %h exp ffff", d); end
    cpu_rd(12'h010, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL feat_lo got %h exp 1", d); end
    cpu_wr(12'h014, 32'd1);
    cpu_rd(12'h010, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL feat_hi got %h exp 12345678", d); end
    cpu_wr(12'h014, 32'd2);
    cpu_rd(12'h010, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL feat_sel2 got %h exp 0", d); end
    cpu_rd(12'h100, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL cap_lo got %h exp 12345678", d); end
    cpu_rd(12'h104, d);
    checks++; if (d !== 32'h0000_00ab) begin errors++; $display("FAIL cap_hi got %h exp ab", d); end
    cpu_rd(12'h200, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped got %h exp 0", d); end
  endtask
  task automatic test_queue_regs;
    logic [31:0] d;
    cpu_rd(12'h034, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL qnummax got %h exp 8", d); end
    cpu_wr(12'h038, 32'd9);
    cpu_rd(12'h038, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL qnum_over got %h exp 0", d); end
    cpu_wr(12'h038, 32'd8);
    cpu_rd(12'h038, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL qnum_max got %h exp 8", d); end
    w_cpu_we = 1; w_cpu_addr = 12'h080; w_cpu_wdata = 32'h1000;
    w_mc_we = 1; w_mc_addr = 12'h008; w_mc_wdata = 32'h2000;
    @(posedge CLK); #1;
    w_cpu_we = 0; w_mc_we = 0;
    cpu_rd(12'h080, d);
    checks++; if (d !== 32'h1000) begin errors++; $display("FAIL collide_cpu got %h exp 1000", d); end
    mc_rd(12'h008, d);
    checks++; if (d !== 32'h1000) begin errors++; $display("FAIL collide_mc got %h exp 1000", d); end
    w_mc_we = 1; w_mc_addr = 12'h030; w_mc_wdata = 32'habcd;
    @(posedge CLK); #1;
    w_mc_we = 0;
    cpu_wr(12'h030, 32'd1);
    cpu_rd(12'h090, d);
    checks++; if (d !== 32'habcd) begin errors++; $display("FAIL q1_avail got %h exp abcd", d); end
    cpu_wr(12'h038, 32'd5);
    mc_rd(12'h024, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL mc_q1_num got %h exp 5", d); end
    cpu_wr(12'h030, 32'd2);
    cpu_rd(12'h034, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oob_qnummax got %h exp 0", d); end
    cpu_wr(12'h080, 32'h55);
    cpu_rd(12'h080, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oob_desc got %h exp 0", d); end
    w_mc_we = 1; w_mc_addr = 12'h048; w_mc_wdata = 32'h77;
    @(posedge CLK); #1;
    w_mc_we = 0;
    mc_rd(12'h048, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mc_oob got %h exp 0", d); end
    cpu_wr(12'h030, 32'd0);
    cpu_rd(12'h080, d);
    checks++; if (d !== 32'h1000) begin errors++; $display("FAIL q0_desc_kept got %h exp 1000", d); end
  endtask
  task automatic test_notify;
    cpu_wr(12'h050, 32'd1);
    cpu_wr(12'h050, 32'd1);
    cpu_wr(12'h050, 32'd0);
    checks++; if ({w_req, w_qsel, w_qnum} !== {1'b1, 4'd1, 32'd5}) begin errors++; $display("FAIL notify_head got %b/%h/%h exp 1/1/5", w_req, w_qsel, w_qnum); end
    ack;
    checks++; if ({w_req, w_qsel, w_qnum} !== {1'b1, 4'd0, 32'd8}) begin errors++; $display("FAIL notify_second got %b/%h/%h exp 1/0/8", w_req, w_qsel, w_qnum); end
    ack;
    checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL notify_coalesce got %b exp 0", w_req); end
    ack;
    checks++; if ({w_req, w_qsel, w_qnum} !== 37'd0) begin errors++; $display("FAIL ack_empty got %b/%h/%h exp 0", w_req, w_qsel, w_qnum); end
    cpu_wr(12'h050, 32'd2);
    checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL notify_oob got %b exp 0", w_req); end
  endtask
  task automatic test_back_to_back;
    cpu_wr(12'h050, 32'd0);
    w_ack = 1; w_cpu_we = 1; w_cpu_addr = 12'h050; w_cpu_wdata = 32'd0;
    @(posedge CLK); #1;
    w_ack = 0; w_cpu_we = 0;
    checks++; if ({w_req, w_qsel} !== {1'b1, 4'd0}) begin errors++; $display("FAIL popush_req got %b/%h exp 1/0", w_req, w_qsel); end
    ack;
    checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL popush_once got %b exp 0", w_req); end
  endtask
  task automatic test_irq;
    logic [31:0] d;
    w_used = 1; w_cpu_we = 1; w_cpu_addr = 12'h064; w_cpu_wdata = 32'd1;
    @(posedge CLK); #1;
    w_used = 0; w_cpu_we = 0;
    checks++; if (w_irq !== 1'b1) begin errors++; $display("FAIL irq_setwins got %b exp 1", w_irq); end
    cpu_rd(12'h060, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL isr_used got %h exp 1", d); end
    cpu_wr(12'h064, 32'd1);
    checks++; if (w_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", w_irq); end
  endtask
  task automatic test_soft_reset;
    logic [31:0] d;
    cpu_wr(12'h070, 32'hf);
    cpu_rd(12'h070, d);
    checks++; if (d !== 32'hf) begin errors++; $display("FAIL status_rw got %h exp f", d); end
    cpu_wr(12'h030, 32'd1);
    cpu_wr(12'h050, 32'd1);
    w_cfg_chg = 1;
    @(posedge CLK); #1;
    w_cfg_chg = 0;
    checks++; if ({w_req, w_irq} !== 2'b11) begin errors++; $display("FAIL pre_srst got %b exp 11", {w_req, w_irq}); end
    cpu_rd(12'h060, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL isr_cfg got %h exp 2", d); end
    cpu_wr(12'h070, 32'd0);
    checks++; if ({w_req, w_irq} !== 2'b00) begin errors++; $display("FAIL srst_out got %b exp 00", {w_req, w_irq}); end
    cpu_rd(12'h0fc, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL srst_cfggen got %h exp 1", d); end
    cpu_rd(12'h030, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL srst_qsel got %h exp 0", d); end
    cpu_rd(12'h038, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL srst_qnum got %h exp 0", d); end
    cpu_wr(12'h050, 32'd1);
    checks++; if ({w_req, w_qsel} !== {1'b1, 4'd1}) begin errors++; $display("FAIL srst_pending got %b/%h exp 1/1", w_req, w_qsel); end
  endtask
  initial begin
    test_reset;
    test_ids;
    test_queue_regs;
    test_notify;
    test_back_to_back;
    test_irq;
    test_soft_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
